mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the multi-cycle RV32I core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. It consumes the per-instruction decode signals of the combinational control unit and emits per-cycle enables for the PC, IR, ALU-out, MDR, register file and CSR file. It also owns the instruction/data memory request handshakes, access timeouts, trap entry, debug halt, and the retired-instruction counter.

---
 rtl/mc_pkg.sv | 26 ++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/mc_sequencer.sv | 153 +++++++++++++++
 tb/tb_mc_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP,
    ST_HALT
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_TGT  = 2'b01;
  localparam logic [1:0] PC_SEL_TRAP = 2'b10;

  localparam logic [3:0] CAUSE_IFAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_LFAULT  = 4'd5;
  localparam logic [3:0] CAUSE_SFAULT  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating memory-handshake wait counter; timeout_o flags the last allowed wait cycle.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam int unsigned W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires while the TIMEOUT-th consecutive wait cycle is in progress.
  assign timeout_o = (TIMEOUT != 0) && inc_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping, traps, debug halt, instret.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_csr_we,
  input  logic             dec_illegal,
  input  logic             dec_ecall,
  input  logic             dec_ebreak,
  input  logic             branch_taken,
  input  logic             halt_req,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             alu_out_load,
  output logic             mdr_load,
  output logic             rf_write,
  output logic             csr_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             trap_valid,
  output logic [3:0]       trap_cause,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [3:0]       cause_d;
  logic             wait_inc, wait_clear, wait_timeout;

  logic             imem_req_q, dmem_req_q, dmem_we_q, alu_out_load_q;
  logic             rf_write_q, csr_write_q, pc_write_q, trap_valid_q;
  logic             retire_q, halted_q;
  logic [1:0]       pc_sel_q;
  logic [3:0]       trap_cause_q;
  logic [CNT_W-1:0] instret_q;

  assign wait_inc   = ((state_q == ST_FETCH) && !imem_ready) ||
                      ((state_q == ST_MEM)   && !dmem_ready);
  assign wait_clear = (state_d != state_q);

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wait_clear),
    .inc_i     (wait_inc),
    .timeout_o (wait_timeout)
  );

  always_comb begin
    state_d = state_q;
    cause_d = '0;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IFAULT;
        end
      end
      ST_DECODE: begin
        state_d = ST_TRAP;
        if (dec_illegal)     cause_d = CAUSE_ILLEGAL;
        else if (dec_ebreak) cause_d = CAUSE_BREAK;
        else if (dec_ecall)  cause_d = CAUSE_ECALL;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = (dec_mem_read || dec_mem_write) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_ready) begin
          state_d = ST_WB;
        end else if (wait_timeout) begin
          state_d = ST_TRAP;
          cause_d = dec_mem_write ? CAUSE_SFAULT : CAUSE_LFAULT;
        end
      end
      ST_WB, ST_TRAP, ST_HALT: state_d = halt_req ? ST_HALT : ST_FETCH;
      default:   state_d = ST_RESET;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RESET;
      imem_req_q     <= 1'b0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      alu_out_load_q <= 1'b0;
      rf_write_q     <= 1'b0;
      csr_write_q    <= 1'b0;
      pc_write_q     <= 1'b0;
      pc_sel_q       <= PC_SEL_SEQ;
      trap_valid_q   <= 1'b0;
      trap_cause_q   <= '0;
      retire_q       <= 1'b0;
      halted_q       <= 1'b0;
      instret_q      <= '0;
    end else begin
      state_q        <= state_d;
      imem_req_q     <= (state_d == ST_FETCH);
      dmem_req_q     <= (state_d == ST_MEM);
      dmem_we_q      <= (state_d == ST_MEM) && dec_mem_write;
      alu_out_load_q <= (state_d == ST_EXEC);
      rf_write_q     <= (state_d == ST_WB) && dec_reg_write;
      csr_write_q    <= (state_d == ST_WB) && dec_csr_we;
      pc_write_q     <= (state_d == ST_WB) || (state_d == ST_TRAP);
      if (state_d == ST_TRAP)
        pc_sel_q <= PC_SEL_TRAP;
      else if ((state_d == ST_WB) && (dec_jump || (dec_branch && branch_taken)))
        pc_sel_q <= PC_SEL_TGT;
      else
        pc_sel_q <= PC_SEL_SEQ;
      trap_valid_q   <= (state_d == ST_TRAP);
      trap_cause_q   <= (state_d == ST_TRAP) ? cause_d : 4'd0;
      retire_q       <= (state_d == ST_WB);
      halted_q       <= (state_d == ST_HALT);
      if (retire_q) instret_q <= instret_q + 1'b1;
    end
  end

  assign imem_req     = imem_req_q;
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign ir_load      = (state_q == ST_FETCH) && imem_ready;
  assign alu_out_load = alu_out_load_q;
  assign mdr_load     = (state_q == ST_MEM) && dmem_ready && dec_mem_read;
  assign rf_write     = rf_write_q;
  assign csr_write    = csr_write_q;
  assign pc_write     = pc_write_q;
  assign pc_sel       = pc_sel_q;
  assign trap_valid   = trap_valid_q;
  assign trap_cause   = trap_cause_q;
  assign retire       = retire_q;
  assign halted       = halted_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: per-cycle expected outputs queued with stimulus, popped at negedge.
module tb_mc_sequencer;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_ready = 0, dmem_ready = 0;
  logic dec_reg_write = 0, dec_mem_read = 0, dec_mem_write = 0, dec_branch = 0;
  logic dec_jump = 0, dec_csr_we = 0, dec_illegal = 0, dec_ecall = 0, dec_ebreak = 0;
  logic branch_taken = 0, halt_req = 0;
  logic imem_req, dmem_req, dmem_we, ir_load, alu_out_load, mdr_load;
  logic rf_write, csr_write, pc_write, trap_valid, retire, halted;
  logic [1:0] pc_sel;
  logic [3:0] trap_cause;
  logic [3:0] instret;

  always #5 clk = ~clk;

  mc_sequencer #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_branch(dec_branch), .dec_jump(dec_jump),
    .dec_csr_we(dec_csr_we), .dec_illegal(dec_illegal), .dec_ecall(dec_ecall),
    .dec_ebreak(dec_ebreak), .branch_taken(branch_taken), .halt_req(halt_req),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_load(ir_load),
    .alu_out_load(alu_out_load), .mdr_load(mdr_load), .rf_write(rf_write),
    .csr_write(csr_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .retire(retire),
    .halted(halted), .instret(instret)
  );

  typedef struct packed {
    logic imem_req, dmem_req, dmem_we, ir_load, alu_out_load, mdr_load;
    logic rf_write, csr_write, pc_write;
    logic [1:0] pc_sel;
    logic trap_valid;
    logic [3:0] trap_cause;
    logic retire, halted;
  } ov_t;

  typedef struct packed { ov_t v; logic [3:0] ir; } exp_t;

  typedef struct {
    logic rw, rd, wr, br, jmp, tk, csr, ill, ebk, ecl, hlt;
    int iw, dw;
  } ins_t;

  ov_t obs;
  assign obs = {imem_req, dmem_req, dmem_we, ir_load, alu_out_load, mdr_load,
                rf_write, csr_write, pc_write, pc_sel, trap_valid, trap_cause,
                retire, halted};

  exp_t sbq[$];
  logic [3:0] exp_ir = '0;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic ov_t v_fetch(input logic rdy);
    ov_t v = '0; v.imem_req = 1'b1; v.ir_load = rdy; return v;
  endfunction
  function automatic ov_t v_exec();
    ov_t v = '0; v.alu_out_load = 1'b1; return v;
  endfunction
  function automatic ov_t v_mem(input logic we, input logic mdr);
    ov_t v = '0; v.dmem_req = 1'b1; v.dmem_we = we; v.mdr_load = mdr; return v;
  endfunction
  function automatic ov_t v_wb(input logic rw, input logic csr, input logic tgt);
    ov_t v = '0; v.rf_write = rw; v.csr_write = csr; v.pc_write = 1'b1;
    v.pc_sel = tgt ? 2'b01 : 2'b00; v.retire = 1'b1; return v;
  endfunction
  function automatic ov_t v_trap(input logic [3:0] c);
    ov_t v = '0; v.trap_valid = 1'b1; v.trap_cause = c; v.pc_write = 1'b1;
    v.pc_sel = 2'b10; return v;
  endfunction
  function automatic ov_t v_halt();
    ov_t v = '0; v.halted = 1'b1; return v;
  endfunction

  task automatic cyc_begin();
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string tag, input ov_t v);
    exp_t e;
    sbq.push_back('{v: v, ir: exp_ir});
    @(negedge clk);
    e = sbq.pop_front();
    chk(tag, 32'(obs), 32'(e.v));
    chk({tag, "_instret"}, 32'(instret), 32'(e.ir));
  endtask

  task automatic trap_cycle(input logic [3:0] c);
    cyc_begin();
    imem_ready = 1'b0; dmem_ready = 1'b0;
    expect_out("trap", v_trap(c));
  endtask

  task automatic run_instr(input ins_t t);
    for (int i = 0; ; i++) begin
      cyc_begin();
      {dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump} =
        {t.rw, t.rd, t.wr, t.br, t.jmp};
      {branch_taken, dec_csr_we, dec_illegal, dec_ebreak, dec_ecall} =
        {t.tk, t.csr, t.ill, t.ebk, t.ecl};
      halt_req = 1'b0;
      imem_ready = (i == t.iw);
      expect_out("fetch", v_fetch(i == t.iw));
      if (i == t.iw) break;
      if (i == TO - 1) begin trap_cycle(4'd1); return; end
    end
    cyc_begin();
    imem_ready = 1'b0;
    halt_req = t.hlt;
    expect_out("decode", '0);
    if (t.ill)      begin trap_cycle(4'd2);  return; end
    else if (t.ebk) begin trap_cycle(4'd3);  return; end
    else if (t.ecl) begin trap_cycle(4'd11); return; end
    cyc_begin();
    expect_out("exec", v_exec());
    if (t.rd || t.wr) begin
      for (int i = 0; ; i++) begin
        cyc_begin();
        dmem_ready = (i == t.dw);
        expect_out("mem", v_mem(t.wr, t.rd && (i == t.dw)));
        if (i == t.dw) break;
        if (i == TO - 1) begin trap_cycle(t.wr ? 4'd7 : 4'd5); return; end
      end
    end
    cyc_begin();
    dmem_ready = 1'b0;
    expect_out("wb", v_wb(t.rw, t.csr, t.jmp || (t.br && t.tk)));
    exp_ir = exp_ir + 4'd1;
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin(); halt_req = 1'b1;
      expect_out("halt", v_halt());
    end
    cyc_begin(); halt_req = 1'b0;
    expect_out("halt_rel", v_halt());
  endtask

  function automatic ins_t mk(input logic rw, rd, wr, br, jmp, tk, csr, input int iw, dw);
    ins_t t;
    t = '{rw: rw, rd: rd, wr: wr, br: br, jmp: jmp, tk: tk, csr: csr,
          ill: 1'b0, ebk: 1'b0, ecl: 1'b0, hlt: 1'b0, iw: iw, dw: dw};
    return t;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t t;
    repeat (2) @(posedge clk);
    #1;
    expect_out("in_reset", '0);
    cyc_begin();
    rst_n = 1'b1;
    expect_out("reset_cyc", '0);

    run_instr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));           // ADDI
    run_instr(mk(1, 1, 0, 0, 0, 0, 0, 0, 3));           // LW, ready wins at timeout edge
    run_instr(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));           // BEQ taken
    run_instr(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));           // BEQ not taken
    run_instr(mk(1, 0, 0, 0, 1, 0, 0, 2, 0));           // JAL
    run_instr(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));           // SW
    run_instr(mk(1, 0, 0, 0, 0, 0, 1, 3, 0));           // CSRRW, fetch waits 3
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0); t.ill = 1; t.ebk = 1; run_instr(t);
    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); t.ebk = 1; t.ecl = 1; run_instr(t);
    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); t.ecl = 1; run_instr(t);
    run_instr(mk(1, 0, 0, 0, 0, 0, 0, TO, 0));          // fetch timeout
    run_instr(mk(0, 0, 1, 0, 0, 0, 0, 0, TO));          // store timeout
    run_instr(mk(1, 1, 0, 0, 0, 0, 0, 0, TO));          // load timeout

    for (int k = 0; k < 14; k++) begin
      int m;
      m = int'($urandom_range(0, 2));
      run_instr(mk(1'($urandom_range(0, 1)), m == 1, m == 2, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3))));
    end

    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); t.ebk = 1; t.hlt = 1; run_instr(t);
    halt_hold(2);
    run_instr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    t = mk(0, 0, 1, 0, 0, 0, 0, 0, 1); t.hlt = 1; run_instr(t);
    halt_hold(1);
    run_instr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    t = mk(0, 0, 1, 0, 0, 0, 0, 0, 0); t.hlt = 1; run_instr(t);

    cyc_begin();
    halt_req = 1'b1;
    expect_out("halt_pre_rst", v_halt());
    cyc_begin();
    rst_n = 1'b0;
    exp_ir = '0;
    #1;
    expect_out("rst_in_halt", '0);
    cyc_begin();
    expect_out("rst_hold", '0);
    cyc_begin();
    rst_n = 1'b1; halt_req = 1'b0;
    expect_out("reset_cyc2", '0);
    run_instr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc_begin();
    expect_out("post_fetch", v_fetch(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
